// File: rtl/demux_1to4_buf.sv
// demux_1to4_buf: 1-to-4 demultiplexer with a one-word output register per
// channel, valid/ready handshakes on every side and per-channel word counters.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_data, in_valid         offered input word
//   in_ready                  input accepted this cycle (combinational)
//   sel_a..sel_d              destination selects, priority a > b > c > d
//   out_a..out_d, vld_a..vld_d  channel data registers and their valid flags
//   rdy_a..rdy_d              channel consumers take the held word
//   cnt_a..cnt_d              accepted-word counters, modulo 256
//   nosel_err                 sticky: a word was offered with no select set
module demux_1to4_buf #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sel_a,
   input  logic             sel_b,
   input  logic             sel_c,
   input  logic             sel_d,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             vld_a,
   output logic             vld_b,
   output logic             vld_c,
   output logic             vld_d,
   input  logic             rdy_a,
   input  logic             rdy_b,
   input  logic             rdy_c,
   input  logic             rdy_d,
   output logic [7:0]       cnt_a,
   output logic [7:0]       cnt_b,
   output logic [7:0]       cnt_c,
   output logic [7:0]       cnt_d,
   output logic             nosel_err
);

   logic [3:0]       sel;
   logic [3:0]       rdy;
   logic [3:0]       win;
   logic [3:0]       free;
   logic [3:0]       fill;
   logic [3:0]       drain;
   logic [3:0]       vld_q;
   logic [WIDTH-1:0] data_q [4];
   logic [7:0]       cnt_q [4];
   logic             nosel_q;

   assign sel = {sel_d, sel_c, sel_b, sel_a};
   assign rdy = {rdy_d, rdy_c, rdy_b, rdy_a};

   // Isolate the lowest set bit: channel a sits at bit 0, so it wins.
   assign win = sel & (~sel + 4'd1);

   // A channel can take a word if empty or draining in the same cycle.
   assign free = ~vld_q | rdy;

   assign in_ready = !rst && |(win & free);
   assign fill     = (in_valid && in_ready) ? win : 4'b0000;
   assign drain    = vld_q & rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= 4'b0000;
         nosel_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            cnt_q[i]  <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (fill[i]) begin
               data_q[i] <= in_data;
               vld_q[i]  <= 1'b1;
               cnt_q[i]  <= cnt_q[i] + 8'd1;
            end else if (drain[i]) begin
               vld_q[i]  <= 1'b0;
            end
         end
         if (in_valid && sel == 4'b0000)
            nosel_q <= 1'b1;
      end
   end

   assign out_a = data_q[0];
   assign out_b = data_q[1];
   assign out_c = data_q[2];
   assign out_d = data_q[3];

   assign vld_a = vld_q[0];
   assign vld_b = vld_q[1];
   assign vld_c = vld_q[2];
   assign vld_d = vld_q[3];

   assign cnt_a = cnt_q[0];
   assign cnt_b = cnt_q[1];
   assign cnt_c = cnt_q[2];
   assign cnt_d = cnt_q[3];

   assign nosel_err = nosel_q;

endmodule

// File: tb/tb_demux_1to4_buf.sv
// tb_demux_1to4_buf: directed scenarios plus randomized traffic checked
// against per-channel word queues and counters kept in the bench.
module tb_demux_1to4_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       sel_a, sel_b, sel_c, sel_d;
   logic [3:0] out_a, out_b, out_c, out_d;
   logic       vld_a, vld_b, vld_c, vld_d;
   logic       rdy_a, rdy_b, rdy_c, rdy_d;
   logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
   logic       nosel_err;

   int n_tests = 0;
   int n_fail  = 0;

   // reference state
   logic [3:0] wq [4][$];
   logic [3:0] mlast [4];
   int         mcnt [4];
   logic       mnosel;

   demux_1to4_buf #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .sel_d(sel_d),
      .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
      .vld_a(vld_a), .vld_b(vld_b), .vld_c(vld_c), .vld_d(vld_d),
      .rdy_a(rdy_a), .rdy_b(rdy_b), .rdy_c(rdy_c), .rdy_d(rdy_d),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d),
      .nosel_err(nosel_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         wq[i].delete();
         mlast[i] = 4'h0;
         mcnt[i]  = 0;
      end
      mnosel = 1'b0;
   endtask

   // One cycle: drive inputs after the falling edge, compare outputs,
   // then advance the reference for the coming rising edge.
   task automatic step(input logic [3:0] s, input logic [3:0] r,
                       input logic v, input logic [3:0] d,
                       input logic rs);
      logic [3:0] ov [4];
      logic [3:0] vv;
      logic [7:0] cv [4];
      logic [3:0] got;
      int         w;
      logic       er;
      @(negedge clk);
      {sel_d, sel_c, sel_b, sel_a} = s;
      {rdy_d, rdy_c, rdy_b, rdy_a} = r;
      in_valid = v;
      in_data  = d;
      rst      = rs;
      #1;
      ov = '{out_a, out_b, out_c, out_d};
      vv = {vld_d, vld_c, vld_b, vld_a};
      cv = '{cnt_a, cnt_b, cnt_c, cnt_d};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("vld[%0d]", i), vv[i], wq[i].size() != 0);
         check($sformatf("out[%0d]", i), ov[i], mlast[i]);
         check($sformatf("cnt[%0d]", i), cv[i], mcnt[i] % 256);
      end
      check("nosel_err", nosel_err, mnosel);
      w = -1;
      for (int i = 3; i >= 0; i--)
         if (s[i]) w = i;
      er = !rs && w >= 0 && (wq[w].size() == 0 || r[w]);
      check("in_ready", in_ready, er);
      if (rs) begin
         model_reset();
      end else begin
         for (int i = 0; i < 4; i++)
            if (wq[i].size() != 0 && r[i]) begin
               got = wq[i].pop_front();
               check($sformatf("drain[%0d]", i), ov[i], got);
            end
         if (v && er) begin
            wq[w].push_back(d);
            mlast[w] = d;
            mcnt[w]++;
         end
         if (v && s == 4'b0000) mnosel = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 4'h0;
      {sel_d, sel_c, sel_b, sel_a} = 4'b0;
      {rdy_d, rdy_c, rdy_b, rdy_a} = 4'b0;
      model_reset();
      @(posedge clk);
      step(4'b0000, 4'b0000, 1'b0, 4'h0, 1'b1);

      // b and c selected: b wins
      step(4'b0110, 4'b0000, 1'b1, 4'hA, 1'b0);
      step(4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);
      check("s1 vld_b", vld_b, 1'b1);
      check("s1 out_b", out_b, 4'hA);
      check("s1 vld_c", vld_c, 1'b0);
      check("s1 cnt_b", cnt_b, 8'd1);

      // stall on a, then fill while draining
      step(4'b0000, 4'b1111, 1'b0, 4'h0, 1'b1);
      step(4'b0001, 4'b0000, 1'b1, 4'h3, 1'b0);
      step(4'b0001, 4'b0000, 1'b1, 4'h5, 1'b0);
      check("s2 stall ready", in_ready, 1'b0);
      check("s2 hold out_a", out_a, 4'h3);
      step(4'b0001, 4'b0001, 1'b1, 4'h5, 1'b0);
      check("s2 bb ready", in_ready, 1'b1);
      step(4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);
      check("s2 vld_a", vld_a, 1'b1);
      check("s2 out_a", out_a, 4'h5);

      // 256 words into d, counter wraps
      step(4'b0000, 4'b1111, 1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 256; i++)
         step(4'b1000, 4'b1000, 1'b1, 4'(i), 1'b0);
      step(4'b0000, 4'b1000, 1'b0, 4'h0, 1'b0);
      check("s3 cnt_d wrap", cnt_d, 8'd0);

      // offer with no select
      step(4'b0000, 4'b0000, 1'b1, 4'h7, 1'b0);
      step(4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);
      check("s4 nosel", nosel_err, 1'b1);
      for (int i = 0; i < 3; i++)
         step(4'b0001, 4'b1111, 1'b0, 4'h0, 1'b0);
      check("s4 sticky", nosel_err, 1'b1);

      // reset overrides buffered words and a pending transfer
      step(4'b0001, 4'b0000, 1'b1, 4'h9, 1'b0);
      step(4'b0100, 4'b0000, 1'b1, 4'h6, 1'b0);
      step(4'b0001, 4'b0000, 1'b1, 4'hF, 1'b1);
      check("s5 rst ready", in_ready, 1'b0);
      step(4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);
      check("s5 vld", {vld_d, vld_c, vld_b, vld_a}, 4'b0000);
      check("s5 cnt_a", cnt_a, 8'd0);
      check("s5 out_a", out_a, 4'h0);
      check("s5 nosel", nosel_err, 1'b0);

      // randomized traffic
      for (int i = 0; i < 10000; i++)
         step(4'($urandom), 4'($urandom), 1'($urandom),
              4'($urandom), $urandom_range(499, 0) == 0);
      step(4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
